// File: rtl/mram_access_sequencer.sv
// ---------------------------------------------------------------------------
// mram_access_sequencer
//
// Purpose:
//   Timing front-end for the 2Kx16 MRAM part model. Turns a single-word
//   req/busy/done handshake into ordered E_n/G_n/W_n strobe sequences. Address
//   and data are held stable for SETUP_CYC cycles before a strobe and for
//   HOLD_CYC cycles after it. G_n and W_n are never low together, and the DQ
//   driver is never enabled while G_n is low.
//
// Optional feature (macro MRAM_WRITE_VERIFY_EN):
//   When defined, every write is followed by a read-back of the same address
//   before done. A mismatch sets the sticky verify_err flag. Verify reads never
//   update rdata. When undefined, verify_err is tied low.
//
// Ports:
//   SIM_CLK, SIM_RST        clock (rising edge) / asynchronous active-high reset
//   req, we, addr, wdata    request; sampled only while idle
//   busy, done              handshake status; done is a one-cycle pulse
//   rdata                   last read word, held until the next read completes
//   verify_err              sticky write-verify mismatch flag
//   mem_addr .. mem_dq_oe   registered MRAM pin drives
//   mem_dq_in               DQ value sensed from the MRAM
//
// Access length, counting the request cycle and the done cycle:
//   SETUP_CYC + ACCESS_CYC + HOLD_CYC + 2 cycles. A write with verify
//   enabled takes 2*(SETUP_CYC + ACCESS_CYC + HOLD_CYC) + 2 cycles.
// ---------------------------------------------------------------------------
module mram_access_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int ACCESS_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        verify_err,
    output logic [15:0] mem_addr,
    output logic        mem_e_n,
    output logic        mem_g_n,
    output logic        mem_w_n,
    output logic        mem_lb_n,
    output logic        mem_ub_n,
    output logic [15:0] mem_dq_out,
    output logic        mem_dq_oe,
    input  logic [15:0] mem_dq_in
);

`ifdef MRAM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // Each phase counts down from N-1 to 0, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LD   = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD_ACC,
        S_WR_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_zero;
    logic             we_q;
    logic             vfy_q;      // current SETUP/RD_ACC/HOLD pass is a read-back
    logic             busy_q;
    logic             done_q;
    logic [15:0]      rdata_q;
    logic [15:0]      mem_addr_q;
    logic [15:0]      mem_dq_out_q;
    logic             mem_dq_oe_q;
    logic             mem_e_n_q;
    logic             mem_g_n_q;
    logic             mem_w_n_q;
    logic             mem_lb_n_q;
    logic             mem_ub_n_q;
`ifdef MRAM_WRITE_VERIFY_EN
    logic             verr_q;
`endif

    always_comb begin
        cnt_zero = (cnt_q == '0);
        cnt_d    = cnt_q - 1'b1;
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            vfy_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_dq_out_q <= '0;
            mem_dq_oe_q  <= 1'b0;
            mem_e_n_q    <= 1'b1;
            mem_g_n_q    <= 1'b1;
            mem_w_n_q    <= 1'b1;
            mem_lb_n_q   <= 1'b1;
            mem_ub_n_q   <= 1'b1;
`ifdef MRAM_WRITE_VERIFY_EN
            verr_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        // Address, data and DQ direction are set up with all
                        // strobes still high; strobes only move after SETUP.
                        state_q      <= S_SETUP;
                        cnt_q        <= SETUP_LD;
                        we_q         <= we;
                        vfy_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        mem_addr_q   <= addr;
                        mem_dq_out_q <= wdata;
                        mem_dq_oe_q  <= we;
                        mem_lb_n_q   <= 1'b0;
                        mem_ub_n_q   <= 1'b0;
                    end
                end

                S_SETUP: begin
                    if (cnt_zero) begin
                        mem_e_n_q <= 1'b0;
                        cnt_q     <= ACC_LD;
                        if (we_q && !vfy_q) begin
                            mem_w_n_q <= 1'b0;
                            state_q   <= S_WR_PULSE;
                        end else begin
                            mem_g_n_q <= 1'b0;
                            state_q   <= S_RD_ACC;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RD_ACC: begin
                    if (cnt_zero) begin
                        mem_e_n_q <= 1'b1;
                        mem_g_n_q <= 1'b1;
                        state_q   <= S_HOLD;
                        cnt_q     <= HOLD_LD;
                        if (vfy_q) begin
`ifdef MRAM_WRITE_VERIFY_EN
                            // mem_dq_out_q still holds the word just written.
                            if (mem_dq_in != mem_dq_out_q) begin
                                verr_q <= 1'b1;
                            end
`endif
                        end else begin
                            rdata_q <= mem_dq_in;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_WR_PULSE: begin
                    if (cnt_zero) begin
                        mem_e_n_q <= 1'b1;
                        mem_w_n_q <= 1'b1;
                        state_q   <= S_HOLD;
                        cnt_q     <= HOLD_LD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_HOLD: begin
                    if (cnt_zero) begin
                        if (VERIFY && we_q && !vfy_q) begin
                            // Turn the DQ driver off at the start of the
                            // read-back SETUP, well before G_n drops.
                            vfy_q       <= 1'b1;
                            mem_dq_oe_q <= 1'b0;
                            state_q     <= S_SETUP;
                            cnt_q       <= SETUP_LD;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DONE: begin
                    // req is ignored here, which forces one idle cycle
                    // between accesses.
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    vfy_q       <= 1'b0;
                    mem_dq_oe_q <= 1'b0;
                    mem_lb_n_q  <= 1'b1;
                    mem_ub_n_q  <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_e_n    = mem_e_n_q;
    assign mem_g_n    = mem_g_n_q;
    assign mem_w_n    = mem_w_n_q;
    assign mem_lb_n   = mem_lb_n_q;
    assign mem_ub_n   = mem_ub_n_q;
    assign mem_dq_out = mem_dq_out_q;
    assign mem_dq_oe  = mem_dq_oe_q;
`ifdef MRAM_WRITE_VERIFY_EN
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mram_access_sequencer.sv
// Bench for mram_access_sequencer. It contains a pin-level 2Kx16 MRAM model
// (power-up pattern 0o40000, 11-bit word select), a table of directed
// accesses, hand-written corner sequences, and a randomized stream. The stream
// is scored against a word-level model that tracks memory contents, accept and
// done timing, and strobe counts.
module tb_mram_access_sequencer;
    localparam int S = 2, A = 3, H = 1;
`ifdef MRAM_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic        busy, done, verify_err;
    logic [15:0] rdata, mem_addr, mem_dq_out, mem_dq_in;
    logic        mem_e_n, mem_g_n, mem_w_n, mem_lb_n, mem_ub_n, mem_dq_oe;

    mram_access_sequencer #(.SETUP_CYC(S), .ACCESS_CYC(A), .HOLD_CYC(H), .CNT_W(4)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .verify_err(verify_err), .mem_addr(mem_addr), .mem_e_n(mem_e_n),
        .mem_g_n(mem_g_n), .mem_w_n(mem_w_n), .mem_lb_n(mem_lb_n),
        .mem_ub_n(mem_ub_n), .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe),
        .mem_dq_in(mem_dq_in)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // Part model. When corrupt is set, bit 0 of the sensed word is flipped.
    logic [15:0] pmem [0:2047] = '{default: 16'o40000};
    logic        corrupt = 1'b0;
    always @(posedge SIM_CLK)
        if (!mem_e_n && !mem_w_n) pmem[mem_addr[10:0]] <= mem_dq_out;
    assign mem_dq_in = (!mem_e_n && !mem_g_n) ? (pmem[mem_addr[10:0]] ^ {15'd0, corrupt}) : 16'h0000;

    // Word-level reference model state.
    logic [15:0] shadow [0:2047];
    bit          known  [0:2047];
    logic [15:0] exp_rd;
    bit          exp_rd_ok;
    bit          exp_verr;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int lat_of(input bit w);
        return (w && VFY) ? 2 * (S + A + H) + 2 : S + A + H + 2;
    endfunction

    // These invariants must hold in every cycle, including during reset.
    always @(negedge SIM_CLK) begin
        chk("g_w_both_low", {31'd0, mem_g_n | mem_w_n}, 32'd1);
        chk("oe_while_g_low", {31'd0, !(mem_dq_oe && !mem_g_n)}, 32'd1);
    end

    // One access through the handshake. The request inputs are scrambled
    // while busy. lat counts cycles from the request cycle through the done
    // cycle, both inclusive.
    task automatic do_access(input bit w, input logic [15:0] a, input logic [15:0] d,
                             output int lat, output int wl, output int gl, output bit pin_ok);
        int k;
        lat = 0; wl = 0; gl = 0; pin_ok = 1;
        @(negedge SIM_CLK);
        req = 1; we = w; addr = a; wdata = d;
        @(posedge SIM_CLK); #1;
        req = 1'($urandom); we = ~w; addr = 16'($urandom); wdata = 16'($urandom);
        for (k = 1; k <= 40; k++) begin
            @(posedge SIM_CLK); #1;
            if (!mem_w_n) wl++;
            if (!mem_g_n) gl++;
            if (mem_addr !== a) pin_ok = 0;
            if (!mem_w_n && mem_dq_out !== d) pin_ok = 0;
            if (!w && mem_dq_oe) pin_ok = 0;
            if (done) begin lat = k + 2; break; end
        end
        req = 0;
        chk("access_done_seen", {31'd0, lat != 0}, 32'd1);
        if (w) begin
            shadow[a[10:0]] = d; known[a[10:0]] = 1;
        end else if (known[a[10:0]]) begin
            exp_rd = shadow[a[10:0]]; exp_rd_ok = 1;
        end else exp_rd_ok = 0;
        @(posedge SIM_CLK); #1;   // DONE -> IDLE
    endtask

    // Cycle-accurate stream checked against the model. With hammer set, req
    // is held high and we alternates per accepted access, for 20 accesses.
    task automatic run_stream(input int ncyc, input bit hammer);
        int e, free_e, done_e, n_acc, n_done, wl, gl;
        bit inflight, c_we, c_known, addr_ok;
        logic [15:0] c_a, c_d, c_exp, r;
        e = 0; free_e = 0; done_e = -1; n_acc = 0; n_done = 0; inflight = 0;
        wl = 0; gl = 0; c_we = 0; c_known = 0; addr_ok = 1;
        c_a = 0; c_d = 0; c_exp = 0;
        while (((hammer ? (n_acc < 20) : (e < ncyc)) || inflight) && e < 4000) begin
            @(negedge SIM_CLK);
            r = 16'($urandom);
            if (hammer) begin
                req = (n_acc < 20); we = n_acc[0];
            end else begin
                req = (e < ncyc) && ($urandom_range(0, 2) == 0); we = 1'($urandom);
            end
            addr = {r[15:11], 6'd0, r[4:0]};
            wdata = 16'($urandom);
            @(posedge SIM_CLK);
            if (!inflight && e >= free_e && req) begin
                inflight = 1; n_acc++;
                c_we = we; c_a = addr; c_d = wdata;
                done_e = e + lat_of(we) - 2;
                wl = 0; gl = 0; addr_ok = 1;
                c_known = known[addr[10:0]]; c_exp = shadow[addr[10:0]];
                if (we) begin shadow[addr[10:0]] = wdata; known[addr[10:0]] = 1; end
            end
            #1;
            if (inflight) begin
                if (!mem_w_n) wl++;
                if (!mem_g_n) gl++;
                if (mem_addr !== c_a) addr_ok = 0;
            end
            chk("stream_busy", {31'd0, busy}, {31'd0, inflight});
            chk("stream_done", {31'd0, done}, {31'd0, inflight && e == done_e});
            if (inflight && e == done_e) begin
                n_done++;
                chk("stream_addr_hold", {31'd0, addr_ok}, 32'd1);
                chk("stream_w_low_cycles", wl, c_we ? A : 0);
                chk("stream_g_low_cycles", gl, c_we ? (VFY ? A : 0) : A);
                if (!c_we) begin
                    if (c_known) begin
                        chk("stream_rdata", {16'd0, rdata}, {16'd0, c_exp});
                        exp_rd = c_exp; exp_rd_ok = 1;
                    end else exp_rd_ok = 0;
                end else if (exp_rd_ok) begin
                    chk("stream_rdata_held", {16'd0, rdata}, {16'd0, exp_rd});
                end
                inflight = 0; free_e = e + 2;
            end
            e++;
        end
        req = 0;
        chk("stream_no_timeout", {31'd0, e < 4000}, 32'd1);
        chk("stream_done_count", n_done, n_acc);
        if (hammer) chk("hammer_accesses", n_done, 20);
        chk("stream_verify_err", {31'd0, verify_err}, {31'd0, exp_verr});
        @(posedge SIM_CLK); #1;
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        vec_t vt[8];
        int   lat, wl, gl;
        bit   pin_ok, seen, got;

        vt[0] = '{1'b1, 16'h0005, 16'o12345, 16'h0000};
        vt[1] = '{1'b0, 16'h0005, 16'h0000, 16'o12345};
        vt[2] = '{1'b0, 16'h07FF, 16'h0000, 16'o40000};
        vt[3] = '{1'b1, 16'h0805, 16'o1,     16'o40000};
        vt[4] = '{1'b0, 16'h0005, 16'h0000, 16'o1};
        vt[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'o1};
        vt[6] = '{1'b0, 16'hF800, 16'h0000, 16'hFFFF};
        vt[7] = '{1'b0, 16'h0805, 16'h0000, 16'o1};

        for (int i = 0; i < 2048; i++) begin shadow[i] = 16'o40000; known[i] = 1; end
        exp_rd = 0; exp_rd_ok = 1; exp_verr = 0;
        req = 0; we = 0; addr = 0; wdata = 0;
        SIM_RST = 1;
        repeat (3) @(posedge SIM_CLK);
        #1;
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_verify_err", {31'd0, verify_err}, 32'd0);
        chk("rst_strobes", {27'd0, mem_e_n, mem_g_n, mem_w_n, mem_lb_n, mem_ub_n}, 32'h1F);
        chk("rst_addr_dq", {mem_addr, mem_dq_out}, 32'd0);
        chk("rst_oe", {31'd0, mem_dq_oe}, 32'd0);
        @(negedge SIM_CLK); SIM_RST = 0;
        @(posedge SIM_CLK); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_access(vt[i].we, vt[i].addr, vt[i].wdata, lat, wl, gl, pin_ok);
            chk($sformatf("vec%0d_latency", i), lat, lat_of(vt[i].we));
            chk($sformatf("vec%0d_w_low", i), wl, vt[i].we ? A : 0);
            chk($sformatf("vec%0d_g_low", i), gl, vt[i].we ? (VFY ? A : 0) : A);
            chk($sformatf("vec%0d_pins", i), {31'd0, pin_ok}, 32'd1);
            chk($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vt[i].exp_rd});
        end

        // Write verify: the sensed word differs from the written word in bit 0.
        corrupt = 1;
        do_access(1'b1, 16'h0040, 16'o77777, lat, wl, gl, pin_ok);
        corrupt = 0;
        exp_verr = VFY;
        chk("vfy_write_latency", lat, VFY ? 14 : 8);
        chk("vfy_err_set", {31'd0, verify_err}, {31'd0, exp_verr});
        chk("vfy_rdata_untouched", {16'd0, rdata}, {16'd0, exp_rd});
        do_access(1'b1, 16'h0041, 16'h1234, lat, wl, gl, pin_ok);
        chk("vfy_err_sticky", {31'd0, verify_err}, {31'd0, exp_verr});

        // Reset in the middle of a write pulse
        @(negedge SIM_CLK);
        req = 1; we = 1; addr = 16'h0123; wdata = 16'hABCD;
        @(posedge SIM_CLK); #1; req = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge SIM_CLK); #1;
            if (!mem_w_n) seen = 1;
        end
        chk("midrst_reached_wpulse", {31'd0, seen}, 32'd1);
        #1 SIM_RST = 1;
        #1;
        chk("midrst_strobes", {29'd0, mem_e_n, mem_w_n, mem_g_n}, 32'h7);
        chk("midrst_oe_busy_done", {29'd0, mem_dq_oe, busy, done}, 32'd0);
        @(negedge SIM_CLK); SIM_RST = 0;
        known[11'h123] = 0; exp_rd = 0; exp_rd_ok = 1; exp_verr = 0;
        chk("midrst_rdata_cleared", {16'd0, rdata}, 32'd0);
        chk("midrst_verify_err", {31'd0, verify_err}, 32'd0);
        got = 0;
        repeat (12) begin @(posedge SIM_CLK); #1; if (done) got = 1; end
        chk("midrst_no_done", {31'd0, got}, 32'd0);
        do_access(1'b0, 16'h0005, 16'h0000, lat, wl, gl, pin_ok);
        chk("postrst_latency", lat, 8);
        chk("postrst_rdata", {16'd0, rdata}, {16'd0, 16'o1});

        // req held high with alternating we, then a randomized stream
        run_stream(0, 1'b1);
        run_stream(700, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
